// File: rtl/pipelined_dp_ram.sv
// Simple dual-port RAM (one write port, one read port) with a power-up clear sweep,
// byte-enable writes, range checking and a READ_LAT-deep registered read path.
module pipelined_dp_ram #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 64,
    parameter int                READ_LAT    = 2,
    parameter int                WRITE_FIRST = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL   = '0,
    localparam int               ADDR_W      = $clog2(DEPTH),
    localparam int               NBYTE       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NBYTE-1:0]  wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              wr_err,
    output logic              init_busy
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    logic              run;
    logic              wr_in_range, rd_in_range;
    logic              wr_ok, rd_acc;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read pipeline: stage k holds its word until a new valid entry arrives,
    // so the last stage doubles as the held output register.
    logic [READ_LAT-1:0] pv, pe;
    logic [DATA_W-1:0]   pd [READ_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == INIT) begin
            cnt_next = cnt + ADDR_W'(1);
            if (cnt == LAST) begin
                state_next = RUN;
                cnt_next   = '0;
            end
        end
    end

    assign run         = (state == RUN);
    assign init_busy   = (state == INIT);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);
    assign wr_ok       = run && wr_en && wr_in_range;
    assign rd_acc      = run && rd_en;

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= CLEAR_VAL;
        end else if (wr_ok) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Same-address collision: write-first merges the enabled new bytes into the old word.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (WRITE_FIRST != 0 && wr_ok && wr_addr == rd_addr) begin
                for (int i = 0; i < NBYTE; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pe <= '0;
            for (int k = 0; k < READ_LAT; k++) pd[k] <= '0;
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) begin
                pe[0] <= ~rd_in_range;
                pd[0] <= rd_word;
            end
            for (int k = 1; k < READ_LAT; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    pe[k] <= pe[k-1];
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_err <= 1'b0;
        else     wr_err <= run && wr_en && !wr_in_range;
    end

    assign rd_valid = pv[READ_LAT-1];
    assign rd_err   = pv[READ_LAT-1] & pe[READ_LAT-1];
    assign rd_data  = pd[READ_LAT-1];

endmodule

// File: tb/tb_pipelined_dp_ram.sv
// Directed bench: three RAM configurations share one stimulus stream; each vector
// carries hand-computed results for the default, 48-deep/old-data and 4-latency builds.
module tb_pipelined_dp_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [5:0]  rd_addr;

    logic [2:0][31:0] rd_data;
    logic [2:0]       rd_valid, rd_err, wr_err, init_busy;

    // dut 0: DEPTH 64, READ_LAT 2, write-first
    pipelined_dp_ram #(.DATA_W(32), .DEPTH(64), .READ_LAT(2), .WRITE_FIRST(1), .CLEAR_VAL(32'h0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .rd_err(rd_err[0]), .wr_err(wr_err[0]), .init_busy(init_busy[0]));
    // dut 1: DEPTH 48, READ_LAT 1, old-data
    pipelined_dp_ram #(.DATA_W(32), .DEPTH(48), .READ_LAT(1), .WRITE_FIRST(0), .CLEAR_VAL(32'h0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .rd_err(rd_err[1]), .wr_err(wr_err[1]), .init_busy(init_busy[1]));
    // dut 2: DEPTH 64, READ_LAT 4, write-first
    pipelined_dp_ram #(.DATA_W(32), .DEPTH(64), .READ_LAT(4), .WRITE_FIRST(1), .CLEAR_VAL(32'h0)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
        .rd_err(rd_err[2]), .wr_err(wr_err[2]), .init_busy(init_busy[2]));

    typedef struct {
        logic        wr;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic [5:0]  raddr;
        logic [31:0] exp_ac;
        logic [31:0] exp_b;
        logic        err_b;
        logic        werr_b;
    } vec_t;

    int errors = 0;
    int checks = 0;

    vec_t tbl[$];
    vec_t post_tbl[$];
    vec_t plan[$];
    vec_t idle;
    vec_t junk;
    logic [31:0] exp_q[$];

    int          vcnt [3];
    logic [31:0] vdat [3][8];
    logic        verr [3][8];
    int          vofs [3][8];
    int          wcnt [3];
    int          woff [3];

    function automatic vec_t mk(input logic wr, input logic [5:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic rd, input logic [5:0] ra,
                                input logic [31:0] eac, input logic [31:0] eb,
                                input logic errb, input logic werrb);
        vec_t v;
        v.wr = wr; v.waddr = wa; v.wdata = wd; v.be = be;
        v.rd = rd; v.raddr = ra; v.exp_ac = eac; v.exp_b = eb;
        v.err_b = errb; v.werr_b = werrb;
        return v;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 4;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 1) ? 48 : 64;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en   = v.wr;
        wr_addr = v.waddr;
        wr_data = v.wdata;
        wr_be   = v.be;
        rd_en   = v.rd;
        rd_addr = v.raddr;
    endtask

    // Sample at each falling edge, then apply plan step k; a read applied at step s
    // is expected at offset s + READ_LAT, a write error at offset s + 1.
    task automatic run_window(input int n);
        for (int d = 0; d < 3; d++) begin
            vcnt[d] = 0; wcnt[d] = 0; woff[d] = -1;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rd_valid[d]) begin
                    if (vcnt[d] < 8) begin
                        vdat[d][vcnt[d]] = rd_data[d];
                        verr[d][vcnt[d]] = rd_err[d];
                        vofs[d][vcnt[d]] = k;
                    end
                    vcnt[d]++;
                end
                if (wr_err[d]) begin
                    wcnt[d]++;
                    woff[d] = k;
                end
            end
            if (k < plan.size()) drive(plan[k]);
            else                 drive(idle);
        end
    endtask

    task automatic check_vec(input vec_t v);
        logic [31:0] exp_d;
        logic        exp_e;
        plan.delete();
        plan.push_back(v);
        run_window(8);
        for (int d = 0; d < 3; d++) begin
            exp_d = (d == 1) ? v.exp_b : v.exp_ac;
            exp_e = (d == 1) ? v.err_b : 1'b0;
            if (v.rd) begin
                check_int("rd_count", d, vcnt[d], 1);
                check_int("rd_latency", d, vofs[d][0], lat_of(d));
                check("rd_data", d, vdat[d][0], exp_d);
                check("rd_err", d, {31'b0, verr[d][0]}, {31'b0, exp_e});
                check("rd_hold", d, rd_data[d], exp_d);
            end else begin
                check_int("rd_count", d, vcnt[d], 0);
            end
            if (d == 1 && v.werr_b) begin
                check_int("wr_err_count", d, wcnt[d], 1);
                check_int("wr_err_offset", d, woff[d], 1);
            end else begin
                check_int("wr_err_count", d, wcnt[d], 0);
            end
        end
    endtask

    // Called right after rst deasserts; junk requests during the sweep must be ignored.
    task automatic sweep_measure(input logic use_junk);
        int first [3];
        int stray;
        first = '{0, 0, 0};
        stray = 0;
        for (int k = 1; k <= 100; k++) begin
            if (use_junk && k <= 40) drive(junk);
            else                     drive(idle);
            @(negedge clk);
            stray += $countones({rd_valid, rd_err, wr_err});
            for (int d = 0; d < 3; d++) begin
                if (!init_busy[d] && first[d] == 0) first[d] = k;
            end
        end
        drive(idle);
        for (int d = 0; d < 3; d++) check_int("sweep_len", d, first[d], depth_of(d));
        check_int("init_stray_strobes", 0, stray, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check({tag, "_rd_valid"}, d, {31'b0, rd_valid[d]}, 32'd0);
            check({tag, "_rd_err"}, d, {31'b0, rd_err[d]}, 32'd0);
            check({tag, "_wr_err"}, d, {31'b0, wr_err[d]}, 32'd0);
            check({tag, "_init_busy"}, d, {31'b0, init_busy[d]}, 32'd1);
            check({tag, "_rd_data"}, d, rd_data[d], 32'd0);
        end
    endtask

    initial begin
        int stray;
        idle = mk(0, 6'd0, 32'h0, 4'h0, 0, 6'd0, 32'h0, 32'h0, 0, 0);
        junk = mk(1, 6'd50, 32'hFFFFFFFF, 4'hF, 1, 6'd50, 32'h0, 32'h0, 0, 0);

        //               wr waddr  wdata         be     rd raddr  exp_ac        exp_b         err werr
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd0,  32'h00000000, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd31, 32'h00000000, 32'h00000000, 0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd63, 32'h00000000, 32'h00000000, 1, 0));
        tbl.push_back(mk(1, 6'd5,  32'hDEADBEEF, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(1, 6'd5,  32'h11223344, 4'h5,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd5,  32'hDE22BE44, 32'hDE22BE44, 0, 0));
        tbl.push_back(mk(1, 6'd9,  32'hAAAAAAAA, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(1, 6'd9,  32'h55555555, 4'hF,  1, 6'd9,  32'h55555555, 32'hAAAAAAAA, 0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd9,  32'h55555555, 32'h55555555, 0, 0));
        tbl.push_back(mk(1, 6'd50, 32'h12345678, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 1));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd50, 32'h12345678, 32'h00000000, 1, 0));
        tbl.push_back(mk(1, 6'd7,  32'hCAFEF00D, 4'h0,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd7,  32'h00000000, 32'h00000000, 0, 0));
        tbl.push_back(mk(1, 6'd9,  32'h0000BBCC, 4'h3,  1, 6'd9,  32'h5555BBCC, 32'h55555555, 0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd9,  32'h5555BBCC, 32'h5555BBCC, 0, 0));
        tbl.push_back(mk(1, 6'd12, 32'h0F0F0F0F, 4'hF,  1, 6'd5,  32'hDE22BE44, 32'hDE22BE44, 0, 0));
        tbl.push_back(mk(0, 6'd0,  32'h0,        4'h0,  1, 6'd12, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 0));
        tbl.push_back(mk(1, 6'd1,  32'h11111111, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(1, 6'd2,  32'h22222222, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(1, 6'd3,  32'h33333333, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(1, 6'd4,  32'h44444444, 4'hF,  0, 6'd0,  32'h0,        32'h0,        0, 0));

        post_tbl.push_back(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd5,  32'h00000000, 32'h00000000, 0, 0));
        post_tbl.push_back(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd9,  32'h00000000, 32'h00000000, 0, 0));
        post_tbl.push_back(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd50, 32'h00000000, 32'h00000000, 1, 0));
        post_tbl.push_back(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd20, 32'h00000000, 32'h00000000, 0, 0));

        rst = 1'b1;
        drive(idle);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        sweep_measure(1'b1);

        for (int i = 0; i < tbl.size(); i++) check_vec(tbl[i]);

        // write, then read of the same address on the very next cycle
        plan.delete();
        plan.push_back(mk(1, 6'd20, 32'h13572468, 4'hF, 0, 6'd0, 32'h0, 32'h0, 0, 0));
        plan.push_back(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd20, 32'h0, 32'h0, 0, 0));
        run_window(8);
        for (int d = 0; d < 3; d++) begin
            check_int("wr_then_rd_count", d, vcnt[d], 1);
            check_int("wr_then_rd_latency", d, vofs[d][0], lat_of(d) + 1);
            check("wr_then_rd_data", d, vdat[d][0], 32'h13572468);
        end

        // four back-to-back reads must come back as four consecutive strobes in order
        plan.delete();
        for (int a = 1; a <= 4; a++) plan.push_back(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'(a), 32'h0, 32'h0, 0, 0));
        run_window(12);
        for (int d = 0; d < 3; d++) begin
            exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
            check_int("b2b_count", d, vcnt[d], 4);
            for (int i = 0; i < 4; i++) begin
                check("b2b_data", d, vdat[d][i], exp_q.pop_front());
                check_int("b2b_offset", d, vofs[d][i], lat_of(d) + i);
            end
        end

        // reset with reads in flight, then again in the middle of the sweep
        plan.delete();
        @(negedge clk);
        drive(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd5, 32'h0, 32'h0, 0, 0));
        @(negedge clk);
        drive(mk(0, 6'd0, 32'h0, 4'h0, 1, 6'd5, 32'h0, 32'h0, 0, 0));
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        #1;
        check_reset_outputs("flight_reset");
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            stray += $countones({rd_valid, rd_err, wr_err});
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            stray += $countones({rd_valid, rd_err, wr_err});
        end
        check_int("flushed_reads", 0, stray, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("sweep_reset");
        @(negedge clk);
        rst = 1'b0;
        sweep_measure(1'b0);

        for (int i = 0; i < post_tbl.size(); i++) check_vec(post_tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_dp_ram.md
PIPELINED_DP_RAM -- requirements
Module: pipelined_dp_ram

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 64, number of words; any value >= 2, not required to be a power of 2.
REQ-003 Parameter READ_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-004 Parameter WRITE_FIRST, default 1, collision mode (1 = new data, 0 = old data).
REQ-005 Parameter CLEAR_VAL, default 0, DATA_W-bit word written to every location by the init sweep.
REQ-006 Derived ADDR_W = $clog2(DEPTH), NBYTE = DATA_W/8.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_addr  input  ADDR_W  write address.
REQ-011 wr_data  input  DATA_W  write data.
REQ-012 wr_be  input  NBYTE  byte enables; bit i enables wr_data[8i+7:8i].
REQ-013 rd_en  input  1  read request.
REQ-014 rd_addr  input  ADDR_W  read address.
REQ-015 rd_data  output  DATA_W  read data, meaningful only when rd_valid=1.
REQ-016 rd_valid  output  1  one-cycle strobe marking rd_data valid.
REQ-017 rd_err  output  1  aligned with rd_valid; 1 = that read was out of range.
REQ-018 wr_err  output  1  one-cycle pulse; write was out of range and dropped.
REQ-019 init_busy  output  1  1 while the clear sweep runs; requests ignored.

Function
REQ-020 FSM states: INIT, RUN; reset forces INIT with sweep counter = 0.
REQ-021 INIT: one location per cycle, mem[cnt] <= CLEAR_VAL, cnt increments; after cnt = DEPTH-1 written, next state RUN; sweep takes exactly DEPTH cycles after rst deasserts.
REQ-022 init_busy = 1 in INIT, 0 in RUN; rd_en/wr_en in INIT ignored with no rd_valid, wr_err or rd_err.
REQ-023 RUN write: wr_en=1 and wr_addr < DEPTH updates only byte lanes with wr_be=1; wr_be=0 leaves the word unchanged with no error.
REQ-024 RUN write with wr_addr >= DEPTH: memory unchanged; wr_err=1 on the next cycle for one cycle.
REQ-025 RUN read: rd_en=1 sampled at edge N yields rd_valid=1 and rd_data at edge N+READ_LAT; one read accepted every cycle, no back-pressure.
REQ-026 Reads return data in issue order; each accepted read produces exactly one rd_valid strobe.
REQ-027 Read with rd_addr >= DEPTH: rd_valid=1, rd_err=1, rd_data=0 at the normal latency.
REQ-028 Same-cycle read and write, same in-range address: WRITE_FIRST=1 returns old word merged with enabled new bytes; WRITE_FIRST=0 returns old word.
REQ-029 Same-cycle read and write to different addresses: independent, no stall.
REQ-030 A read issued the cycle after a write to the same address SHALL return the written data (both modes).
REQ-031 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-032 rst=1 asynchronously forces rd_data=0, rd_valid=0, rd_err=0, wr_err=0, init_busy=1, state INIT, cnt=0, and flushes the read pipeline.
REQ-033 Reads in flight when rst asserts SHALL produce no rd_valid strobe.
REQ-034 rst mid-sweep or mid-RUN restarts the full DEPTH-cycle sweep after deassertion; contents after the sweep are all CLEAR_VAL.

Verification
REQ-035 Reset, then poll: init_busy=1 for exactly 64 cycles (DEPTH=64), then 0; read of addresses 0, 31 and 63 -> rd_data=0x00000000, rd_err=0.
REQ-036 Write addr 5 = 0xDEADBEEF, wr_be=4'b1111; then write addr 5 = 0x11223344, wr_be=4'b0101; read addr 5 -> 0xDE22BE44 exactly 2 cycles after rd_en.
REQ-037 Collision: mem[9]=0xAAAAAAAA; same cycle write 9 = 0x55555555 (be=4'b1111) and read 9 -> 0x55555555 with WRITE_FIRST=1, 0xAAAAAAAA with WRITE_FIRST=0.
REQ-038 DEPTH=48: write addr 50 -> wr_err pulse, no memory change; read addr 50 -> rd_valid=1, rd_err=1, rd_data=0.
REQ-039 Back-to-back reads of addresses 1,2,3,4 on consecutive cycles -> four consecutive rd_valid strobes in order, for READ_LAT = 1 and 4.
REQ-040 Assert rst with 2 reads in flight and mid-sweep -> no rd_valid, init_busy=1 immediately, full sweep repeats, previously written data reads back as 0.
